// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - LED drive generator: steady, blink and burst patterns from a shared prescaler
//
// Ports:
//   i_clock        single clock, all logic on its rising edge
//   i_reset        synchronous active-high reset
//   i_enable       run enable; low forces IDLE
//   i_mode         00 off, 01 steady on, 10 blink, 11 burst
//   i_half_period  prescaler terminal count (tick every i_half_period+1 cycles)
//   i_burst_len    pulses per burst (0 treated as 1)
//   o_clock        registered LED drive for the downstream led_control stage
//   o_tick         one-cycle strobe at each prescaler wrap
//   o_count        current prescaler value
//   o_busy         high while burst pulses are in progress
//
// Build option: define BLINK_BURST_EN to compile in burst mode; otherwise
// mode 11 behaves as mode 10 and o_busy is tied low.

module blink_gen #(
  parameter int CNT_W     = 27,
  parameter int GAP_TICKS = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_half_period,
  input  logic [3:0]       i_burst_len,
  output logic             o_clock,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b11;

`ifdef BLINK_BURST_EN
  localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  // Last gap-counter value before leaving BURST_GAP.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    ON,
    BLINK,
    BURST_HI,
    BURST_LO,
    BURST_GAP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    ON,
    BLINK
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             clock_q, clock_d;
  logic             tick_q, tick_d;
  logic [1:0]       mode_q;
  logic             run;
  logic             wrap;

`ifdef BLINK_BURST_EN
  logic             busy_q, busy_d;
  logic [3:0]       burst_q, burst_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       burst_len_eff;

  assign burst_len_eff = (i_burst_len == 4'd0) ? 4'd1 : i_burst_len;
`else
  logic unused_burst_len;
  assign unused_burst_len = ^i_burst_len;
`endif

  assign run  = i_enable && (i_mode != MODE_OFF);
  // >= rather than == so that lowering i_half_period below the current
  // count wraps immediately instead of running the counter round.
  assign wrap = (count_q >= i_half_period);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clock_d = clock_q;
    tick_d  = 1'b0;
`ifdef BLINK_BURST_EN
    burst_d = burst_q;
    gap_d   = gap_q;
`endif

    if (!run) begin
      state_d = IDLE;
      count_d = '0;
      clock_d = 1'b0;
`ifdef BLINK_BURST_EN
      burst_d = 4'd0;
      gap_d   = '0;
`endif
    end else if ((state_q == IDLE) || (i_mode != mode_q)) begin
      // Entry into a mode (from idle or on a mode change): restart the
      // prescaler; any tick this cycle is discarded.
      count_d = '0;
      case (i_mode)
        MODE_ON: begin
          state_d = ON;
          clock_d = 1'b1;
        end
`ifdef BLINK_BURST_EN
        MODE_BURST: begin
          state_d = BURST_HI;
          clock_d = 1'b1;
          burst_d = burst_len_eff;
          gap_d   = '0;
        end
`endif
        default: begin
          state_d = BLINK;
          clock_d = 1'b0;
        end
      endcase
    end else if (state_q == ON) begin
      count_d = '0;
      clock_d = 1'b1;
    end else if (!wrap) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = '0;
      tick_d  = 1'b1;
      case (state_q)
        BLINK: clock_d = ~clock_q;
`ifdef BLINK_BURST_EN
        BURST_HI: begin
          state_d = BURST_LO;
          clock_d = 1'b0;
          burst_d = burst_q - 4'd1;
        end
        BURST_LO: begin
          if (burst_q != 4'd0) begin
            state_d = BURST_HI;
            clock_d = 1'b1;
          end else if (GAP_TICKS == 0) begin
            state_d = BURST_HI;
            clock_d = 1'b1;
            burst_d = burst_len_eff;
          end else begin
            state_d = BURST_GAP;
            clock_d = 1'b0;
            gap_d   = '0;
          end
        end
        BURST_GAP: begin
          if (gap_q >= GAP_LAST) begin
            state_d = BURST_HI;
            clock_d = 1'b1;
            burst_d = burst_len_eff;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
`endif
        default: begin
          state_d = IDLE;
          clock_d = 1'b0;
        end
      endcase
    end

`ifdef BLINK_BURST_EN
    // Busy is registered alongside the state it describes.
    busy_d = (state_d == BURST_HI) || (state_d == BURST_LO);
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      count_q <= '0;
      clock_q <= 1'b0;
      tick_q  <= 1'b0;
      mode_q  <= MODE_OFF;
`ifdef BLINK_BURST_EN
      busy_q  <= 1'b0;
      burst_q <= 4'd0;
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clock_q <= clock_d;
      tick_q  <= tick_d;
      mode_q  <= i_mode;
`ifdef BLINK_BURST_EN
      busy_q  <= busy_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
`endif
    end
  end

  assign o_clock = clock_q;
  assign o_tick  = tick_q;
  assign o_count = count_q;
`ifdef BLINK_BURST_EN
  assign o_busy  = busy_q;
`else
  assign o_busy  = 1'b0;
`endif

endmodule
